alu_seq: RTL and testbench

- Sequencing arithmetic unit directly upstream of the accumulator register.
- Takes operand A from the accumulator output and operand B from the bus. Produces a 12-bit result on alu_out with a one-cycle alu_to_ac write strobe, which the accumulator consumes.
- ADD/SUB/logic/pass complete in one cycle. MUL (shift-add) and DIV (restoring) are iterative over N cycles.

---
 rtl/alu_seq.sv | 136 +++++++++++++
 tb/tb_alu_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequencing ALU feeding the accumulator: single-cycle ADD/SUB/logic/pass,
// iterative shift-add MUL and restoring DIV over N cycles.
module alu_seq #(
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] alu_out,
  output logic         alu_to_ac,
  output logic         busy,
  output logic         z_flag,
  output logic         c_flag,
  output logic         err
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state_q;
  logic             is_div_q;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [N-1:0]     quo_q;
  logic [N-1:0]     rem_q;
  logic [2*N-1:0]   prod_q;
  logic [CW-1:0]    cnt_q;

  logic [N:0]       sum_w;
  logic [N:0]       diff_w;
  logic [N-1:0]     fast_res;
  logic             fast_c;
  logic [N:0]       rem_sh;
  logic [N-1:0]     rem_sub;
  logic [2*N-1:0]   partial;
  logic [N-1:0]     done_res;

  always_comb begin
    sum_w    = {1'b0, a} + {1'b0, b};
    diff_w   = {1'b0, a} - {1'b0, b};
    fast_res = '0;
    fast_c   = 1'b0;
    case (op)
      3'd0: begin fast_res = sum_w[N-1:0];  fast_c = sum_w[N];  end
      3'd1: begin fast_res = diff_w[N-1:0]; fast_c = diff_w[N]; end
      3'd4: fast_res = b;
      3'd5: fast_res = a & b;
      3'd6: fast_res = a | b;
      3'd7: fast_res = a ^ b;
      default: ;
    endcase
  end

  // Restoring step: the remainder stays below b, so the subtraction fits N bits.
  always_comb begin
    rem_sh   = {rem_q, a_q[N-1]};
    rem_sub  = rem_sh[N-1:0] - b_q;
    partial  = b_q[cnt_q] ? ({{N{1'b0}}, a_q} << cnt_q) : '0;
    done_res = is_div_q ? quo_q : prod_q[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      alu_out   <= '0;
      alu_to_ac <= 1'b0;
      busy      <= 1'b0;
      z_flag    <= 1'b0;
      c_flag    <= 1'b0;
      err       <= 1'b0;
    end else begin
      alu_to_ac <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (op == 3'd2 || op == 3'd3) begin
              is_div_q <= (op == 3'd3);
              a_q      <= a;
              b_q      <= b;
              quo_q    <= '0;
              rem_q    <= '0;
              prod_q   <= '0;
              cnt_q    <= '0;
              busy     <= 1'b1;
              state_q  <= ITER;
            end else begin
              alu_out   <= fast_res;
              z_flag    <= (fast_res == '0);
              c_flag    <= fast_c;
              err       <= 1'b0;
              alu_to_ac <= 1'b1;
            end
          end
        end
        ITER: begin
          if (is_div_q) begin
            a_q <= a_q << 1;
            if (rem_sh >= {1'b0, b_q}) begin
              rem_q <= rem_sub;
              quo_q <= {quo_q[N-2:0], 1'b1};
            end else begin
              rem_q <= rem_sh[N-1:0];
              quo_q <= {quo_q[N-2:0], 1'b0};
            end
          end else begin
            prod_q <= prod_q + partial;
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N-1)) state_q <= DONE;
        end
        DONE: begin
          alu_out   <= done_res;
          z_flag    <= (done_res == '0);
          c_flag    <= is_div_q ? 1'b0 : |prod_q[2*N-1:N];
          err       <= is_div_q && (b_q == '0);
          alu_to_ac <= 1'b1;
          busy      <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised bench for alu_seq against a countdown-based arithmetic model,
// plus directed transactions pinned to hand-computed results.
module tb_alu_seq;
  localparam int N = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] alu_out;
  logic         alu_to_ac;
  logic         busy;
  logic         z_flag;
  logic         c_flag;
  logic         err;

  always #5 clk = ~clk;

  alu_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .alu_out(alu_out), .alu_to_ac(alu_to_ac), .busy(busy),
    .z_flag(z_flag), .c_flag(c_flag), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Model state: expected outputs plus a countdown for the iterative ops.
  int           rem_cnt = 0;
  logic [N-1:0] e_out = '0, p_out = '0;
  logic         e_pulse = 0, e_busy = 0, e_z = 0, e_c = 0, e_err = 0;
  logic         p_c = 0, p_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic ref_op(input logic [2:0] o, input int x, input int y,
                        output logic [N-1:0] r, output logic cf, output logic ef);
    int v;
    cf = 0; ef = 0; v = 0;
    case (o)
      3'd0: begin v = x + y; cf = (v > 4095); end
      3'd1: begin v = x - y; cf = (x < y); end
      3'd2: begin v = x * y; cf = (v > 4095); end
      3'd3: begin
        if (y == 0) begin v = 4095; ef = 1; end
        else v = x / y;
      end
      3'd4: v = y;
      3'd5: v = x & y;
      3'd6: v = x | y;
      default: v = x ^ y;
    endcase
    r = N'(v & 4095);
  endtask

  task automatic model_edge();
    logic [N-1:0] r;
    logic cf, ef;
    if (rst) begin
      rem_cnt = 0; e_out = '0; e_pulse = 0; e_busy = 0; e_z = 0; e_c = 0; e_err = 0;
    end else begin
      e_pulse = 0;
      if (rem_cnt > 0) begin
        rem_cnt--;
        if (rem_cnt == 0) begin
          e_busy = 0; e_pulse = 1;
          e_out = p_out; e_c = p_c; e_err = p_err; e_z = (p_out == 0);
        end
      end else if (start) begin
        ref_op(op, int'(a), int'(b), r, cf, ef);
        if (op == 3'd2 || op == 3'd3) begin
          rem_cnt = N + 1; e_busy = 1;
          p_out = r; p_c = cf; p_err = ef;
        end else begin
          e_pulse = 1; e_out = r; e_c = cf; e_err = ef; e_z = (r == 0);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("alu_to_ac", 32'(alu_to_ac), 32'(e_pulse));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("alu_out", 32'(alu_out), 32'(e_out));
      chk("z_flag", 32'(z_flag), 32'(e_z));
      chk("c_flag", 32'(c_flag), 32'(e_c));
      chk("err", 32'(err), 32'(e_err));
    end
  end

  task automatic issue(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    start = 1; op = o; a = x; b = y;
    step();
    start = 0;
  endtask

  // Waits for the completion pulse; lat counts edges after the start edge.
  task automatic wait_pulse(input string name, output int lat, output int busy_cnt);
    lat = 0; busy_cnt = busy ? 1 : 0;
    while (!alu_to_ac && lat < 40) begin
      step();
      lat++;
      if (busy) busy_cnt++;
    end
    if (!alu_to_ac) chk({name, "_timeout"}, 32'(0), 32'(1));
    $display("txn %s: out=%0h z=%0b c=%0b err=%0b lat=%0d", name, alu_out, z_flag, c_flag, err, lat);
  endtask

  initial begin
    int lat, bc, pulses;
    rst = 1; start = 0; op = 0; a = 0; b = 0;
    step();
    chk_en = 1;
    step();
    chk("rst_out", 32'(alu_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 0;

    issue(3'd0, 12'h005, 12'h003);
    $display("txn add: out=%0h pulse=%0b", alu_out, alu_to_ac);
    chk("add_out", 32'(alu_out), 32'h008);
    chk("add_pulse", 32'(alu_to_ac), 32'h1);
    step();
    chk("add_pulse_once", 32'(alu_to_ac), 32'h0);

    issue(3'd0, 12'hFFF, 12'h001);
    $display("txn add_wrap: out=%0h z=%0b c=%0b", alu_out, z_flag, c_flag);
    chk("wrap_out", 32'(alu_out), 32'h000);
    chk("wrap_z", 32'(z_flag), 32'h1);
    chk("wrap_c", 32'(c_flag), 32'h1);
    issue(3'd1, 12'h002, 12'h005);
    $display("txn sub: out=%0h c=%0b pulse=%0b", alu_out, c_flag, alu_to_ac);
    chk("sub_out", 32'(alu_out), 32'hFFD);
    chk("sub_c", 32'(c_flag), 32'h1);
    chk("sub_pulse_b2b", 32'(alu_to_ac), 32'h1);
    step();

    issue(3'd2, 12'd25, 12'd40);
    wait_pulse("mul_1000", lat, bc);
    chk("mul_out", 32'(alu_out), 32'd1000);
    chk("mul_c", 32'(c_flag), 32'h0);
    chk("mul_lat", 32'(lat), 32'd13);
    chk("mul_busy_cycles", 32'(bc), 32'd13);
    step();

    issue(3'd2, 12'h100, 12'h100);
    wait_pulse("mul_ovf", lat, bc);
    chk("mulovf_out", 32'(alu_out), 32'h000);
    chk("mulovf_c", 32'(c_flag), 32'h1);
    chk("mulovf_z", 32'(z_flag), 32'h1);
    step();

    issue(3'd3, 12'd1000, 12'd7);
    wait_pulse("div_142", lat, bc);
    chk("div_out", 32'(alu_out), 32'd142);
    chk("div_err", 32'(err), 32'h0);
    step();
    issue(3'd3, 12'd1000, 12'd0);
    wait_pulse("div_zero", lat, bc);
    chk("div0_out", 32'(alu_out), 32'hFFF);
    chk("div0_err", 32'(err), 32'h1);
    chk("div0_c", 32'(c_flag), 32'h0);
    chk("div0_lat", 32'(lat), 32'd13);
    step();
    issue(3'd0, 12'd1, 12'd2);
    $display("txn add_clr: out=%0h err=%0b", alu_out, err);
    chk("err_clear", 32'(err), 32'h0);
    step();

    // Start during a MUL must be ignored.
    issue(3'd2, 12'd123, 12'd30);
    repeat (5) step();
    issue(3'd0, 12'd1, 12'd1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (alu_to_ac) begin
        pulses++;
        chk("mul_ign_out", 32'(alu_out), 32'd3690);
      end
    end
    $display("txn mul_ignore: pulses=%0d", pulses);
    chk("mul_ign_pulses", 32'(pulses), 32'd1);

    // Reset in the middle of a DIV aborts it silently.
    issue(3'd3, 12'd999, 12'd3);
    repeat (6) step();
    rst = 1;
    step();
    rst = 0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_out", 32'(alu_out), 32'h0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (alu_to_ac) pulses++;
    end
    $display("txn div_abort: pulses=%0d", pulses);
    chk("abort_pulses", 32'(pulses), 32'd0);

    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 79) == 0);
      start = ($urandom_range(0, 9) < 7);
      op    = 3'($urandom);
      a     = 12'($urandom);
      b     = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom);
      step();
      if (alu_to_ac)
        $display("txn rand %0d: out=%0h z=%0b c=%0b err=%0b", i, alu_out, z_flag, c_flag, err);
    end
    rst = 0; start = 0;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
